// File: rtl/core_pkg.sv
// Core-wide constants shared by the pipeline stages.
//   Xlen             : address / PC width
//   Ilen             : instruction word width
//   ResetAddrDefault : PC taken out of reset when a stage is not told otherwise
//   FetchDepth       : fetch FIFO entries, which is also the fetch credit limit
package core_pkg;

    localparam int Xlen = 32;
    localparam int Ilen = 32;

    localparam logic [Xlen-1:0] ResetAddrDefault = 32'h0000_0000;
    localparam int              FetchDepth       = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the imem response port and decode.
// Depth x Ilen synchronous FIFO; the head entry is visible combinationally.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write data_i at the tail
//   pop_i        : drop the head entry
//   flush_i      : empty the FIFO; dominates push and pop
//   full_o       : count_o == Depth
//   empty_o      : count_o == 0
//   count_o      : number of valid entries
//   head_o       : entry at the head
module fetch_fifo
    import core_pkg::*;
#(
    parameter int Depth = FetchDepth,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [Ilen-1:0] data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o,
    output logic [Ilen-1:0] head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Ilen-1:0] mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            wr_en;
    logic            rd_en;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage. Owns the fetch PC, issues in-order word requests
// to imem under a credit limit of Depth (outstanding + buffered), buffers the
// returned words and presents {pc_o, instr_o} to decode over valid/ready.
// A redirect re-targets the PC, flushes the buffer and marks every response
// still in flight as stale so it is discarded on arrival.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   redirect_valid_i/pc_i   : re-target fetch; pc bits [1:0] are ignored
//   imem_req_valid_o/ready_i: request handshake, address on imem_req_addr_o
//   imem_rsp_valid_i/data_i : in-order response, never stalled
//   instr_valid_o/ready_i   : decode handshake, instr_o at pc_o
module fetch
    import core_pkg::*;
#(
    parameter logic [Xlen-1:0] ResetAddr = ResetAddrDefault,
    parameter int              Depth     = FetchDepth
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [Xlen-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [Xlen-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [Ilen-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [Ilen-1:0] instr_o,
    output logic [Xlen-1:0] pc_o
);

    localparam int              CntW     = $clog2(Depth + 1);
    localparam logic [CntW:0]   DepthCnt = (CntW + 1)'(Depth);

    logic [Xlen-1:0] pc_q, pc_d;
    logic [Xlen-1:0] head_pc_q, head_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CntW-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW:0]   credit_used;
    logic            credit_ok;
    logic            req_fire;
    logic            pop;
    logic            push;
    logic            rsp_stale;
    logic [Xlen-1:0] redirect_target;
    logic            unused_pc_bits;

    assign redirect_target = {redirect_pc_i[Xlen-1:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc_i[1:0];

    // Credit counts registered state only: a pop this cycle frees its slot next cycle.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok   = (credit_used < DepthCnt);

    assign imem_req_valid_o = !rst_i && !redirect_valid_i && credit_ok;
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign instr_valid_o = !rst_i && !fifo_empty && !redirect_valid_i;
    assign pc_o          = head_pc_q;
    assign pop           = instr_valid_o && instr_ready_i;

    assign rsp_stale = (drop_cnt_q != '0);
    assign push      = imem_rsp_valid_i && !rsp_stale && !redirect_valid_i;

    always_comb begin
        pc_d          = pc_q;
        head_pc_d     = head_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid_i) begin
            pc_d          = redirect_target;
            head_pc_d     = redirect_target;
            // Everything still in flight after this cycle's response is stale,
            // and this cycle's response is discarded as well.
            outstanding_d = outstanding_q - CntW'(imem_rsp_valid_i);
            drop_cnt_d    = outstanding_q - CntW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + Xlen'(4);
            end
            if (pop) begin
                head_pc_d = head_pc_q + Xlen'(4);
            end
            outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && rsp_stale) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= ResetAddr;
            head_pc_q     <= ResetAddr;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .Depth (Depth),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (imem_rsp_data_i),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (instr_o)
    );

    a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && fifo_full && !pop));
    a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rsp_valid_i && (outstanding_q == '0)));
    a_req_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(req_fire && !imem_rsp_valid_i && ({1'b0, outstanding_q} == DepthCnt)));
    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, outstanding_q} <= DepthCnt));
    a_fifo_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, fifo_count} <= DepthCnt));
    a_drop_within_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        (drop_cnt_q <= outstanding_q));
    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (credit_used <= DepthCnt));

endmodule
